// File: rtl/fmanormpipe_pkg.sv
// Shared configuration for the FMA normalization pipeline: format descriptor
// plus width helpers derived from it.
package fmanormpipe_pkg;

  typedef struct packed {
    int unsigned NE;
    int unsigned NF;
  } cvw_t;

  localparam cvw_t FP32_CFG = '{NE: 32'd8, NF: 32'd23};

  // Sum significand carries three fraction widths plus guard/integer bits.
  function automatic int sum_width(input cvw_t c);
    return int'(32'd3 * c.NF + 32'd4);
  endfunction

  function automatic int cnt_width(input cvw_t c);
    return $clog2(int'(32'd3 * c.NF + 32'd5));
  endfunction

  function automatic int exp_width(input cvw_t c);
    return int'(c.NE + 32'd2);
  endfunction

endpackage

// File: rtl/fmanormpipe_if.sv
// Handshake bus of the normalization pipeline: raw sum in, normalized result out.
interface fmanormpipe_if #(
  parameter int SW = 73,
  parameter int EW = 10,
  parameter int CW = 7
);
  logic          InValid;
  logic          InReady;
  logic [SW-1:0] Sm;
  logic [EW-1:0] Se;
  logic [CW-1:0] SCnt;
  logic          Ss;
  logic          ASticky;
  logic          OutValid;
  logic          OutReady;
  logic [SW-1:0] Mf;
  logic [EW-1:0] Me;
  logic          Ms;
  logic          MSticky;
  logic          MZero;

  modport slave (
    input  InValid, Sm, Se, SCnt, Ss, ASticky, OutReady,
    output InReady, OutValid, Mf, Me, Ms, MSticky, MZero
  );

  modport master (
    output InValid, Sm, Se, SCnt, Ss, ASticky, OutReady,
    input  InReady, OutValid, Mf, Me, Ms, MSticky, MZero
  );
endinterface

// File: rtl/fmanormpipe_chk.sv
// Simulation-only protocol checks for the normalization pipeline.
module fmanormpipe_chk #(
  parameter int SW = 73,
  parameter int EW = 10
) (
  input logic          clk,
  input logic          reset_n,
  input logic          Flush,
  input logic          OutValid,
  input logic          OutReady,
  input logic [SW-1:0] Mf,
  input logic [EW-1:0] Me,
  input logic          Ms,
  input logic          MSticky,
  input logic          MZero,
  input logic          illegal_i
);

  a_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (OutValid && !OutReady && !Flush) |=>
      (OutValid && $stable(Mf) && $stable(Me) && $stable(Ms) && $stable(MSticky) && $stable(MZero)))
    else $error("output changed while stalled");

  a_rst: assert property (@(posedge clk) !reset_n |-> !OutValid)
    else $error("OutValid high during reset");

  a_scnt: assert property (@(posedge clk) disable iff (!reset_n) !illegal_i)
    else $error("nonzero sum shifted out entirely by SCnt");

endmodule

// File: rtl/fmanormshift.sv
// Left-normalizes the sum by the LZA count, fixing the LZA's possible one-bit
// under-count, and flags an exactly-zero sum.
module fmanormshift #(
  parameter int SW       = 73,
  parameter int EW       = 10,
  parameter int CW       = 7,
  parameter bit SKIPCORR = 1'b0
) (
  input  logic [SW-1:0] sm_i,
  input  logic [EW-1:0] se_i,
  input  logic [CW-1:0] scnt_i,
  output logic [SW-1:0] mf_o,
  output logic [EW-1:0] me_o,
  output logic          mzero_o
);

  logic [SW-1:0] t_s;
  logic [EW-1:0] me_raw_s;
  logic          corr_s;

  // Shift, exponent adjust and zero override; counts past SW shift everything out.
  always_comb begin
    t_s      = sm_i << scnt_i;
    me_raw_s = se_i - EW'(scnt_i);
    corr_s   = ~t_s[SW-1] & ~SKIPCORR;
    mf_o     = '0;
    me_o     = '0;
    mzero_o  = 1'b0;
    if (sm_i == '0) begin
      mzero_o = 1'b1;
    end else if (corr_s) begin
      mf_o = {t_s[SW-2:0], 1'b0};
      me_o = me_raw_s - {{(EW-1){1'b0}}, 1'b1};
    end else begin
      mf_o = t_s;
      me_o = me_raw_s;
    end
  end

endmodule

// File: rtl/fmanormpipe.sv
// Elastic two-stage pipeline after the FMA adder: stage 1 captures the raw sum,
// stage 2 holds the normalized significand/exponent for the rounder.
module fmanormpipe
  import fmanormpipe_pkg::*;
#(
  parameter cvw_t P        = FP32_CFG,
  parameter bit   SKIPCORR = 1'b0
) (
  input logic          clk,
  input logic          reset_n,
  input logic          Flush,
  fmanormpipe_if.slave bus
);

  localparam int SW = sum_width(P);
  localparam int CW = cnt_width(P);
  localparam int EW = exp_width(P);

  logic          v1_q, v1_d, v2_q, v2_d;
  logic [SW-1:0] sm1_q, sm1_d;
  logic [EW-1:0] se1_q, se1_d;
  logic [CW-1:0] scnt1_q, scnt1_d;
  logic          ss1_q, ss1_d, st1_q, st1_d;
  logic [SW-1:0] mf_q, mf_d;
  logic [EW-1:0] me_q, me_d;
  logic          ms_q, ms_d, mst_q, mst_d, mz_q, mz_d;

  logic          r2_s, in_ready_s, accept_s, adv_s;
  logic [SW-1:0] mf_s;
  logic [EW-1:0] me_s;
  logic          mzero_s;

  fmanormshift #(.SW(SW), .EW(EW), .CW(CW), .SKIPCORR(SKIPCORR)) u_shift (
    .sm_i   (sm1_q),
    .se_i   (se1_q),
    .scnt_i (scnt1_q),
    .mf_o   (mf_s),
    .me_o   (me_s),
    .mzero_o(mzero_s)
  );

  // Ready chain looks through both stages so a full pipe still streams.
  always_comb begin
    r2_s       = ~v2_q | bus.OutReady;
    in_ready_s = ~v1_q | r2_s;
    accept_s   = bus.InValid & in_ready_s;
    adv_s      = v1_q & r2_s;
  end

  // Next-state for valid bits and data; Flush wins over any accept/advance.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (Flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (accept_s) v1_d = 1'b1;
      else if (adv_s) v1_d = 1'b0;
      else v1_d = v1_q;
      if (adv_s) v2_d = 1'b1;
      else if (r2_s) v2_d = 1'b0;
      else v2_d = v2_q;
    end

    sm1_q_hold: begin
      sm1_d   = sm1_q;
      se1_d   = se1_q;
      scnt1_d = scnt1_q;
      ss1_d   = ss1_q;
      st1_d   = st1_q;
    end
    if (accept_s) begin
      sm1_d   = bus.Sm;
      se1_d   = bus.Se;
      scnt1_d = bus.SCnt;
      ss1_d   = bus.Ss;
      st1_d   = bus.ASticky;
    end else begin
      sm1_d   = sm1_q;
    end

    mf_d  = mf_q;
    me_d  = me_q;
    ms_d  = ms_q;
    mst_d = mst_q;
    mz_d  = mz_q;
    if (adv_s) begin
      mf_d  = mf_s;
      me_d  = me_s;
      ms_d  = ss1_q;
      mst_d = st1_q;
      mz_d  = mzero_s;
    end else begin
      mf_d  = mf_q;
    end
  end

  // Stage registers; async reset clears valids and data together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      sm1_q   <= '0;
      se1_q   <= '0;
      scnt1_q <= '0;
      ss1_q   <= 1'b0;
      st1_q   <= 1'b0;
      mf_q    <= '0;
      me_q    <= '0;
      ms_q    <= 1'b0;
      mst_q   <= 1'b0;
      mz_q    <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      sm1_q   <= sm1_d;
      se1_q   <= se1_d;
      scnt1_q <= scnt1_d;
      ss1_q   <= ss1_d;
      st1_q   <= st1_d;
      mf_q    <= mf_d;
      me_q    <= me_d;
      ms_q    <= ms_d;
      mst_q   <= mst_d;
      mz_q    <= mz_d;
    end
  end

  assign bus.InReady  = in_ready_s;
  assign bus.OutValid = v2_q;
  assign bus.Mf       = mf_q;
  assign bus.Me       = me_q;
  assign bus.Ms       = ms_q;
  assign bus.MSticky  = mst_q;
  assign bus.MZero    = mz_q;

  fmanormpipe_chk #(.SW(SW), .EW(EW)) u_chk (
    .clk      (clk),
    .reset_n  (reset_n),
    .Flush    (Flush),
    .OutValid (v2_q),
    .OutReady (bus.OutReady),
    .Mf       (mf_q),
    .Me       (me_q),
    .Ms       (ms_q),
    .MSticky  (mst_q),
    .MZero    (mz_q),
    .illegal_i(v1_q & ~mzero_s & (mf_s == '0))
  );

endmodule

// File: tb/tb_fmanormpipe.sv
// Scoreboard bench: random and directed sums against a leading-one reference
// model, with backpressure, flush and asynchronous reset scenarios.
module tb_fmanormpipe;
  import fmanormpipe_pkg::*;

  localparam int SW = 73;
  localparam int EW = 10;
  localparam int CW = 7;

  typedef struct {
    logic [SW-1:0] sm;
    logic [EW-1:0] se;
    logic [CW-1:0] scnt;
    logic          ss;
    logic          st;
  } op_t;

  typedef struct {
    logic [SW-1:0] mf;
    logic [EW-1:0] me;
    logic [SW-1:0] mfk;
    logic [EW-1:0] mek;
    logic          ms;
    logic          mst;
    logic          mz;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic Flush;
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  bit   done;
  exp_t q[$];
  exp_t me_pop;
  logic          prev_hold = 1'b0;
  logic [SW-1:0] h_mf;
  logic [EW-1:0] h_me;
  logic          h_ms, h_mst, h_mz;

  fmanormpipe_if #(.SW(SW), .EW(EW), .CW(CW)) bus ();
  fmanormpipe_if #(.SW(SW), .EW(EW), .CW(CW)) bus_k ();

  fmanormpipe dut (.clk(clk), .reset_n(reset_n), .Flush(Flush), .bus(bus));
  fmanormpipe #(.SKIPCORR(1'b1)) dut_k (.clk(clk), .reset_n(reset_n), .Flush(Flush), .bus(bus_k));

  assign bus_k.InValid  = bus.InValid;
  assign bus_k.Sm       = bus.Sm;
  assign bus_k.Se       = bus.Se;
  assign bus_k.SCnt     = bus.SCnt;
  assign bus_k.Ss       = bus.Ss;
  assign bus_k.ASticky  = bus.ASticky;
  assign bus_k.OutReady = bus.OutReady;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] bitp(input int p);
    logic [SW-1:0] o;
    o    = '0;
    o[p] = 1'b1;
    return o;
  endfunction

  // Reference: the true normalization shift is set by the leading one of Sm.
  function automatic exp_t ref_model(input op_t op);
    exp_t e;
    int   p, k;
    e.ms  = op.ss;
    e.mst = op.st;
    if (op.sm == '0) begin
      e.mf = '0; e.me = '0; e.mfk = '0; e.mek = '0; e.mz = 1'b1;
    end else begin
      p = -1;
      for (int i = 0; i < SW; i++) if (op.sm[i]) p = i;
      k     = SW - 1 - p;
      e.mf  = op.sm << k;
      e.me  = EW'(int'(op.se) - k);
      e.mfk = op.sm << op.scnt;
      e.mek = EW'(int'(op.se) - int'(op.scnt));
      e.mz  = 1'b0;
    end
    return e;
  endfunction

  function automatic op_t mk(input logic [SW-1:0] sm, input int se, input int scnt,
                             input logic ss, input logic st);
    op_t o;
    o.sm = sm; o.se = EW'(se); o.scnt = CW'(scnt); o.ss = ss; o.st = st;
    return o;
  endfunction

  // LZA counts are either exact or one short, as the adder produces them.
  function automatic op_t rand_op();
    op_t o;
    int  p, k;
    o.se = EW'($urandom);
    o.ss = 1'($urandom);
    o.st = 1'($urandom);
    if ($urandom_range(0, 15) == 0) begin
      o.sm   = '0;
      o.scnt = CW'($urandom);
    end else begin
      p      = int'($urandom_range(0, SW - 1));
      o.sm   = SW'({$urandom, $urandom, $urandom});
      o.sm   = (o.sm & (bitp(p) - 1'b1)) | bitp(p);
      k      = SW - 1 - p;
      o.scnt = CW'((k > 0 && $urandom_range(0, 1) == 1) ? k - 1 : k);
    end
    return o;
  endfunction

  function automatic op_t rand_nz();
    op_t o;
    o = rand_op();
    if (o.sm == '0) begin
      o.sm   = bitp(SW - 1);
      o.scnt = '0;
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input op_t op);
    bus.Sm      = op.sm;
    bus.Se      = op.se;
    bus.SCnt    = op.scnt;
    bus.Ss      = op.ss;
    bus.ASticky = op.st;
  endtask

  task automatic drive(input op_t op);
    logic acc;
    acc = 1'b0;
    set_in(op);
    bus.InValid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.InReady;
      tick();
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL drive_timeout: actual not accepted required accepted within 50 cycles");
    end
    bus.InValid = 1'b0;
  endtask

  task automatic drain();
    bus.OutReady = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    chk("drain_empty", SW'(q.size()), '0);
  endtask

  task automatic lat_test(input op_t op, input logic [SW-1:0] emf, input logic [EW-1:0] eme,
                          input logic emz, input logic [SW-1:0] emfk, input logic [EW-1:0] emek);
    drive(op);
    chk("lat_n1_valid", bus.OutValid, '0);
    tick();
    chk("lat_n2_valid", bus.OutValid, SW'(1));
    chk("lat_mf", bus.Mf, emf);
    chk("lat_me", bus.Me, eme);
    chk("lat_mzero", bus.MZero, emz);
    chk("lat_mf_nocorr", bus_k.Mf, emfk);
    chk("lat_me_nocorr", bus_k.Me, emek);
  endtask

  // Monitor/scoreboard: all transfers judged at the falling edge, away from updates.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.OutValid, SW'(1));
        chk("hold_mf", bus.Mf, h_mf);
        chk("hold_me", bus.Me, h_me);
        chk("hold_flags", {bus.Ms, bus.MSticky, bus.MZero}, {h_ms, h_mst, h_mz});
      end
      chk("in_ready", bus.InReady, (q.size() < 2) || bus.OutReady);
      chk("lockstep", {bus_k.OutValid, bus_k.InReady}, {bus.OutValid, bus.InReady});
      if (bus.OutValid) begin
        if (q.size() == 0) begin
          chk("spurious_out", bus.OutValid, '0);
        end else if (bus.OutReady) begin
          me_pop = q.pop_front();
          chk("out_mf", bus.Mf, me_pop.mf);
          chk("out_me", bus.Me, me_pop.me);
          chk("out_flags", {bus.Ms, bus.MSticky, bus.MZero}, {me_pop.ms, me_pop.mst, me_pop.mz});
          chk("out_mf_nocorr", bus_k.Mf, me_pop.mfk);
          chk("out_me_nocorr", bus_k.Me, me_pop.mek);
        end
      end
      prev_hold <= bus.OutValid && !bus.OutReady && !Flush;
      h_mf  <= bus.Mf;
      h_me  <= bus.Me;
      h_ms  <= bus.Ms;
      h_mst <= bus.MSticky;
      h_mz  <= bus.MZero;
      if (Flush) begin
        q.delete();
      end else if (bus.InValid && bus.InReady) begin
        q.push_back(ref_model('{sm: bus.Sm, se: bus.Se, scnt: bus.SCnt, ss: bus.Ss, st: bus.ASticky}));
        acc_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t  op;
    exp_t e;
    int   base;
    reset_n = 1'b1;
    Flush   = 1'b0;
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    set_in(mk('0, 0, 0, 1'b0, 1'b0));
    #1 reset_n = 1'b0;
    #2;
    chk("rst_outvalid", bus.OutValid, '0);
    chk("rst_mf", bus.Mf, '0);
    chk("rst_me", bus.Me, '0);
    chk("rst_flags", {bus.Ms, bus.MSticky, bus.MZero}, '0);
    chk("rst_inready", bus.InReady, SW'(1));
    tick();
    tick();
    reset_n = 1'b1;
    bus.OutReady = 1'b1;
    tick();

    lat_test(mk(bitp(72), 127, 0, 1'b0, 1'b0), bitp(72), 10'd127, 1'b0, bitp(72), 10'd127);
    lat_test(mk(bitp(60), 200, 12, 1'b1, 1'b1), bitp(72), 10'd188, 1'b0, bitp(72), 10'd188);
    lat_test(mk(bitp(59), 200, 12, 1'b0, 1'b0), bitp(72), 10'd187, 1'b0, bitp(71), 10'd188);
    lat_test(mk('0, 90, 5, 1'b0, 1'b0), '0, 10'd0, 1'b1, '0, 10'd0);
    lat_test(mk(bitp(50), 3, 22, 1'b0, 1'b0), bitp(72), 10'h3ED, 1'b0, bitp(72), 10'h3ED);
    tick();

    // Backpressure: only two ops fit while the output is stalled.
    bus.OutReady = 1'b0;
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) drive(rand_op());
      end
      begin
        repeat (6) tick();
        chk("bp_accepted", SW'(acc_cnt - base), SW'(2));
        chk("bp_inready", bus.InReady, '0);
        bus.OutReady = 1'b1;
      end
    join
    drain();

    // Flush with both stages full and an input transferring in the same cycle.
    bus.OutReady = 1'b0;
    drive(rand_nz());
    drive(rand_nz());
    set_in(rand_nz());
    bus.InValid  = 1'b1;
    bus.OutReady = 1'b1;
    Flush        = 1'b1;
    tick();
    Flush       = 1'b0;
    bus.InValid = 1'b0;
    chk("flush_outvalid", bus.OutValid, '0);
    chk("flush_inready", bus.InReady, SW'(1));
    op = rand_nz();
    e  = ref_model(op);
    lat_test(op, e.mf, e.me, e.mz, e.mfk, e.mek);
    tick();

    // Asynchronous reset in the middle of a cycle with both stages full.
    bus.OutReady = 1'b0;
    drive(rand_nz());
    drive(rand_nz());
    #2 reset_n = 1'b0;
    #1;
    chk("arst_outvalid", bus.OutValid, '0);
    chk("arst_mf", bus.Mf, '0);
    chk("arst_me", bus.Me, '0);
    tick();
    reset_n = 1'b1;
    bus.OutReady = 1'b1;
    tick();

    // Random traffic under random backpressure.
    done = 1'b0;
    fork
      begin
        while (!done) begin
          tick();
          bus.OutReady = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          drive(rand_op());
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        done = 1'b1;
      end
    join
    drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
